// File: rtl/seq_div_16_8_pkg.sv
// seq_div_16_8 shared types: FSM states, default width and cell
// truth tables used by the divider datapath and its bench model.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CALC,
    DONE
  } state_t;

  localparam int N_DEF = 8;

  // Approximate adder cell: {cout, sum}
  function automatic logic [1:0] approx_cell(
    input logic x,
    input logic y,
    input logic z
  );
    return {x & y & z, x | y | z};
  endfunction

  // Exact full adder cell: {cout, sum}
  function automatic logic [1:0] exact_cell(
    input logic x,
    input logic y,
    input logic z
  );
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/seq_div_16_8_if.sv
// seq_div_16_8 operand/result handshake bundle.
// master drives operands and out_ready; slave is the divider.
interface seq_div_16_8_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           dz;
  logic           ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );
endinterface

// File: rtl/seq_div_16_8_sub_cell_chain.sv
// Ripple subtractor A - B = A + ~B + 1 built from adder cells.
// With APPROX_SUB_EN the low APPROX_BITS cells are approximate.
module sub_cell_chain
  import seq_div_pkg::*;
#(
  parameter int W           = 9,
  parameter int APPROX_BITS = 0
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-2:0] o_d,
  output logic         o_borrow
);

`ifdef APPROX_SUB_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  // Low cells feed the difference; the top cell only yields borrow,
  // its sum is never needed since the kept remainder fits W-1 bits.
  always_comb begin
    logic       c;
    logic [1:0] r;
    c   = 1'b1;
    r   = 2'b00;
    o_d = '0;
    for (int i = 0; i < W - 1; i++) begin
      if (APPROX_ON && i < APPROX_BITS)
        r = approx_cell(i_a[i], ~i_b[i], c);
      else
        r = exact_cell(i_a[i], ~i_b[i], c);
      o_d[i] = r[0];
      c      = r[1];
    end
    r        = exact_cell(i_a[W-1], ~i_b[W-1], c);
    o_borrow = ~r[1];
  end

endmodule

// File: rtl/seq_div_16_8.sv
// Sequential restoring divider, 2N-bit dividend by N-bit divisor.
// Optional APPROX_SUB_EN selects an approximate CALC subtractor.
module seq_div_16_8
  import seq_div_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int APPROX_BITS = 0
) (
  input logic          clk,
  input logic          rst,
  seq_div_16_8_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_next;
  logic [2*N-1:0] r_dd;
  logic [N-1:0]   r_dv;
  logic [N-1:0]   r_p;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_dz;
  logic           r_ovf;

  logic           w_xfer;
  logic           w_div0;
  logic           w_big;
  logic           w_last;
  logic [N:0]     w_shift;
  logic [N-1:0]   w_d;
  logic           w_borrow;
  logic [N-1:0]   w_p_nxt;
  logic [N-1:0]   w_q_nxt;

  assign w_xfer  = bus.in_valid && (r_state == IDLE);
  assign w_div0  = (r_dv == '0);
  assign w_big   = (r_dd[2*N-1:N] >= r_dv);
  assign w_last  = (r_cnt == CW'(1));
  assign w_shift = {r_p, r_q[N-1]};

  sub_cell_chain #(
    .W          (N + 1),
    .APPROX_BITS(APPROX_BITS)
  ) u_sub (
    .i_a     (w_shift),
    .i_b     ({1'b0, r_dv}),
    .o_d     (w_d),
    .o_borrow(w_borrow)
  );

  assign w_p_nxt = w_borrow ? w_shift[N-1:0] : w_d;
  assign w_q_nxt = {r_q[N-2:0], ~w_borrow};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_xfer) w_next = CHECK;
      CHECK: w_next = (w_div0 || w_big) ? DONE : CALC;
      CALC:  if (w_last) w_next = DONE;
      DONE:  if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dd   <= '0;
      r_dv   <= '0;
      r_p    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_dd <= bus.dividend;
            r_dv <= bus.divisor;
          end
        end
        CHECK: begin
          if (w_div0) begin
            r_quot <= '1;
            r_rem  <= r_dd[N-1:0];
            r_dz   <= 1'b1;
            r_ovf  <= 1'b0;
          end else if (w_big) begin
            r_quot <= '1;
            r_rem  <= '1;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b1;
          end else begin
            r_p   <= r_dd[2*N-1:N];
            r_q   <= r_dd[N-1:0];
            r_cnt <= CW'(N);
            r_dz  <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        CALC: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_p_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dz        = r_dz;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_seq_div_16_8.sv
// Bench for seq_div_16_8: directed cases plus random ops against
// an arithmetic reference (cell-chain model with APPROX_SUB_EN).
module tb_seq_div_16_8;
  import seq_div_pkg::*;

  localparam int N  = 8;
  localparam int AB = 3;
`ifdef APPROX_SUB_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_div_16_8_if #(.N(N)) bus ();

  seq_div_16_8 #(
    .N          (N),
    .APPROX_BITS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // {quotient, remainder, dz, ovf}
  function automatic logic [17:0] ref_model(
    input logic [15:0] dd,
    input logic [7:0]  dv
  );
    logic [8:0] p;
    logic [7:0] q;
    logic [8:0] a;
    logic [8:0] t;
    logic [8:0] nb;
    logic       c;
    logic [1:0] r;
    if (dv == 8'h00) return {8'hFF, dd[7:0], 2'b10};
    if (dd[15:8] >= dv) return {8'hFF, 8'hFF, 2'b01};
    if (!APPROX)
      return {8'(dd / dv), 8'(dd % dv), 2'b00};
    p  = {1'b0, dd[15:8]};
    q  = dd[7:0];
    nb = ~{1'b0, dv};
    for (int k = 0; k < 8; k++) begin
      a = {p[7:0], q[7]};
      c = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (i < AB) r = approx_cell(a[i], nb[i], c);
        else        r = 2'(a[i]) + 2'(nb[i]) + 2'(c);
        t[i] = r[0];
        c    = r[1];
      end
      if (c) begin
        p = t;
        q = {q[6:0], 1'b1};
      end else begin
        p = a;
        q = {q[6:0], 1'b0};
      end
    end
    return {q, p[7:0], 2'b00};
  endfunction

  function automatic logic [17:0] pick(
    input logic [15:0] dd,
    input logic [7:0]  dv,
    input logic [17:0] k
  );
    return APPROX ? ref_model(dd, dv) : k;
  endfunction

  task automatic run_op(
    input logic [15:0] dd,
    input logic [7:0]  dv,
    input logic [17:0] exp,
    input int          exp_lat,
    input int          hold,
    input bit          poke,
    input string       name
  );
    int          lat;
    int          guard;
    logic [17:0] got;
    logic [19:0] seen;
    @(negedge clk);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL %s accept: in_ready stuck 0", name);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    bus.out_ready = (hold == 0);
    n_chk++;
    if (!bus.out_valid) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid never 1", name);
      return;
    end
    if (exp_lat > 0) begin
      n_chk++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d",
                 name, lat, exp_lat);
      end
    end
    got = {bus.quotient, bus.remainder, bus.dz, bus.ovf};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s result %h/%h: got %h want %h",
               name, dd, dv, got, exp);
    end
`ifndef APPROX_SUB_EN
    if (got[1:0] == 2'b00) begin
      n_chk++;
      if (int'(dd) != int'(got[17:10]) * int'(dv) + int'(got[9:2])
          || got[9:2] >= dv) begin
        n_fail++;
        $display("FAIL %s invariant %h/%h: q=%h r=%h",
                 name, dd, dv, got[17:10], got[9:2]);
      end
    end
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.dividend = 16'h00FF;
        bus.divisor  = 8'h01;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      seen = {bus.out_valid, bus.in_ready, bus.quotient,
              bus.remainder, bus.dz, bus.ovf};
      n_chk++;
      if (seen !== {2'b10, got}) begin
        n_fail++;
        $display("FAIL %s hold: got %h want %h",
                 name, seen, {2'b10, got});
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s release: vld/rdy %b want 01",
               name, {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset();
    logic [19:0] v;
    @(negedge clk);
    v = {bus.in_ready, bus.out_valid, bus.quotient,
         bus.remainder, bus.dz, bus.ovf};
    n_chk++;
    if (v !== {2'b10, 18'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", v, {2'b10, 18'h0});
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    run_op(16'h1234, 8'h56,
           pick(16'h1234, 8'h56, {8'h36, 8'h10, 2'b00}),
           10, 0, 1'b0, "div_1234_56");
    run_op(16'hFE01, 8'hFF,
           pick(16'hFE01, 8'hFF, {8'hFF, 8'h00, 2'b00}),
           10, 0, 1'b0, "div_fe01_ff");
  endtask

  task automatic test_flags();
    run_op(16'h1234, 8'h12, {8'hFF, 8'hFF, 2'b01},
           2, 0, 1'b0, "ovf");
    run_op(16'hABCD, 8'h00, {8'hFF, 8'hCD, 2'b10},
           2, 0, 1'b0, "dz");
  endtask

  task automatic test_backpressure();
    run_op(16'h1234, 8'h56,
           pick(16'h1234, 8'h56, {8'h36, 8'h10, 2'b00}),
           10, 5, 1'b1, "bp_hold");
    run_op(16'h00FF, 8'h01,
           pick(16'h00FF, 8'h01, {8'hFF, 8'h00, 2'b00}),
           10, 0, 1'b0, "bp_next");
  endtask

  task automatic test_reset_mid();
    bit vld_seen;
    @(negedge clk);
    bus.dividend = 16'h1234;
    bus.divisor  = 8'h56;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid async: rdy/vld %b want 10",
               {bus.in_ready, bus.out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    vld_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) vld_seen = 1'b1;
    end
    n_chk++;
    if (vld_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid ghost: out_valid seen %b want 0",
               vld_seen);
    end
    run_op(16'h0064, 8'h0A,
           pick(16'h0064, 8'h0A, {8'h0A, 8'h00, 2'b00}),
           10, 0, 1'b0, "rst_next");
  endtask

  task automatic test_random();
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [17:0] e;
    for (int k = 0; k < 3000; k++) begin
      dv = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dv = 8'h00;
      dd = 16'($urandom);
      if (dv != 0 && $urandom_range(0, 3) != 0)
        dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = ref_model(dd, dv);
      run_op(dd, dv, e, (e[1:0] != 2'b00) ? 2 : 10,
             $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    test_reset();
    test_normal();
    test_flags();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
